// File: rtl/led_seq_pkg.sv
// Shared types and framing constants for the LED frame sequencer.
package led_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CTRL,
        ST_SETTLE,
        ST_DATA
    } state_e;

    localparam logic [7:0] CMD_DISP_CTRL = 8'h80;
    localparam logic [7:0] CMD_ADDR_BASE = 8'hC0;
    localparam logic [7:0] POS_CTRL      = 8'hFF;

    function automatic logic [7:0] ctrl_byte(input logic disp_on, input logic [2:0] bright);
        return CMD_DISP_CTRL | {4'b0000, disp_on, bright};
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running refresh counter 0..PERIOD-1; o_tick is high during the wrap cycle.
module led_tick_gen #(
    parameter int unsigned PERIOD = 12_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic o_tick
);

    localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        o_tick = (cnt_q == CNT_LAST);
        cnt_d  = o_tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_frame_sequencer.sv
// Streams a host-written DEPTH-byte frame (control byte, settle pause, data bytes) to the LED byte writer.
// Build option LED_SEQ_DIRTY_EN: periodic ticks refresh only when pixels or control settings changed.
module led_frame_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned CLK_HZ        = 12_000_000,
    parameter int unsigned REFRESH_HZ    = 1,
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned SETTLE_CYCLES = 1200,
    parameter int unsigned AW            = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [7:0]    i_wr_data,
    input  logic [2:0]    i_bright,
    input  logic          i_disp_on,
    input  logic          i_force,
    input  logic          i_busy,
    output logic          o_valid,
    output logic [7:0]    o_pos,
    output logic [7:0]    o_value,
    output logic          o_frame_busy,
    output logic          o_frame_done,
    output logic          o_tick
);

    localparam int unsigned PERIOD      = CLK_HZ / REFRESH_HZ;
    localparam int unsigned SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [AW-1:0] IDX_LAST    = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_W     = (AW + 1)'(DEPTH);

    state_e        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [SW-1:0] settle_q, settle_d;
    logic          force_pend_q, force_pend_d;
    logic          valid_q, valid_d;
    logic [7:0]    pos_q, pos_d;
    logic [7:0]    value_q, value_d;
    logic          done_q, done_d;
    logic [7:0]    fb_q [DEPTH];
    logic [7:0]    fb_d [DEPTH];

    logic tick, tick_start, start, issue, wr_ok;

    led_tick_gen #(.PERIOD(PERIOD)) u_tick (
        .clk    (CLK),
        .rst    (RST),
        .o_tick (tick)
    );

`ifdef LED_SEQ_DIRTY_EN
    logic       dirty_q, dirty_d;
    logic [3:0] last_ctrl_q, last_ctrl_d;
    logic [3:0] ctrl_now;

    assign ctrl_now   = {i_disp_on, i_bright};
    assign tick_start = tick && dirty_q;

    // Control drift only counts while idle; a frame being sent picks up the new value itself.
    always_comb begin
        dirty_d     = start ? wr_ok
                            : (dirty_q || wr_ok || (state_q == ST_IDLE && ctrl_now != last_ctrl_q));
        last_ctrl_d = (state_q == ST_CTRL && issue) ? ctrl_now : last_ctrl_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dirty_q     <= 1'b1;
            last_ctrl_q <= '0;
        end else begin
            dirty_q     <= dirty_d;
            last_ctrl_q <= last_ctrl_d;
        end
    end
`else
    assign tick_start = tick;
`endif

    assign wr_ok = i_wr_en && ({1'b0, i_wr_addr} < DEPTH_W);
    assign start = (state_q == ST_IDLE) && (tick_start || force_pend_q);
    assign issue = !i_busy && !valid_q;

    always_comb begin
        fb_d = fb_q;
        if (wr_ok) begin
            fb_d[i_wr_addr] = i_wr_data;
        end
        force_pend_d = start ? 1'b0 : (force_pend_q || i_force);
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        valid_d  = 1'b0;
        pos_d    = pos_q;
        value_d  = value_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CTRL;
                end
            end
            ST_CTRL: begin
                if (issue) begin
                    valid_d  = 1'b1;
                    pos_d    = POS_CTRL;
                    value_d  = ctrl_byte(i_disp_on, i_bright);
                    settle_d = '0;
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    idx_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            ST_DATA: begin
                // Buffer read is combinational, so a same-cycle host write to idx is not seen here.
                if (issue) begin
                    valid_d = 1'b1;
                    pos_d   = CMD_ADDR_BASE | 8'(idx_q);
                    value_d = fb_q[idx_q];
                    if (idx_q == IDX_LAST) begin
                        done_d  = 1'b1;
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + AW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            settle_q     <= '0;
            force_pend_q <= 1'b0;
            valid_q      <= 1'b0;
            pos_q        <= '0;
            value_q      <= '0;
            done_q       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                fb_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            settle_q     <= settle_d;
            force_pend_q <= force_pend_d;
            valid_q      <= valid_d;
            pos_q        <= pos_d;
            value_q      <= value_d;
            done_q       <= done_d;
            fb_q         <= fb_d;
        end
    end

    assign o_valid      = valid_q;
    assign o_pos        = pos_q;
    assign o_value      = value_q;
    assign o_frame_done = done_q;
    assign o_frame_busy = (state_q != ST_IDLE);
    assign o_tick       = tick;

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Randomized bench: a frame-level reference model predicts every issued byte and its cycle; a monitor checks them.
module tb_led_frame_sequencer;

    localparam int P      = 100;
    localparam int DEPTH  = 4;
    localparam int SETTLE = 20;
    localparam int AW     = 2;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          i_wr_en = 1'b0;
    logic [AW-1:0] i_wr_addr = '0;
    logic [7:0]    i_wr_data = '0;
    logic [2:0]    i_bright = 3'd1;
    logic          i_disp_on = 1'b1;
    logic          i_force = 1'b0;
    logic          i_busy = 1'b0;
    logic          o_valid, o_frame_busy, o_frame_done, o_tick;
    logic [7:0]    o_pos, o_value;

    led_frame_sequencer #(
        .CLK_HZ(P), .REFRESH_HZ(1), .DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE)
    ) dut (
        .CLK(CLK), .RST(RST),
        .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
        .i_bright(i_bright), .i_disp_on(i_disp_on), .i_force(i_force), .i_busy(i_busy),
        .o_valid(o_valid), .o_pos(o_pos), .o_value(o_value),
        .o_frame_busy(o_frame_busy), .o_frame_done(o_frame_done), .o_tick(o_tick)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         cyc;
        logic [7:0] pos;
        logic [7:0] val;
        logic       done;
    } exp_t;

    exp_t expq[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   busy_len = 0;

    always @(posedge CLK) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, expv);
        end
    endtask

    // Reference model: a frame is a list of DEPTH+1 bytes; byte k may go out once the writer is idle
    // and its earliest slot has arrived (settle gap after the control byte, 2-cycle spacing otherwise).
    bit         m_active = 0;
    int         m_bi = 0;
    int         m_next_ok = 0;
    bit         m_pend = 0;
    bit         m_dirty = 1;
    logic [3:0] m_last_ctrl = '0;
    logic [7:0] m_buf [DEPTH];
    int         m_n = 0;
    bit         m_tk, m_go, m_started, m_was_active, m_wr;
    exp_t       m_e;

    always @(negedge CLK or posedge RST) begin
        if (RST) begin
            m_active = 0; m_bi = 0; m_next_ok = 0; m_pend = 0; m_dirty = 1;
            m_last_ctrl = '0; m_n = 0;
            for (int i = 0; i < DEPTH; i++) m_buf[i] = 8'h00;
            expq.delete();
        end else begin
            m_tk = ((m_n % P) == P - 1);
            chk("tick", o_tick, m_tk);
            chk("frame_busy", o_frame_busy, m_active);
            m_was_active = m_active;
            m_started = 0;
`ifdef LED_SEQ_DIRTY_EN
            m_go = m_tk && m_dirty;
`else
            m_go = m_tk;
`endif
            if (!m_active) begin
                if (m_go || m_pend) begin
                    m_active = 1; m_started = 1; m_bi = 0; m_next_ok = cyc + 1;
                end
            end else if (cyc >= m_next_ok && !i_busy) begin
                m_e.cyc = cyc + 1;
                if (m_bi == 0) begin
                    m_e.pos  = 8'hFF;
                    m_e.val  = 8'(128 + (i_disp_on ? 8 : 0) + int'(i_bright));
                    m_e.done = 0;
                    m_last_ctrl = {i_disp_on, i_bright};
                    m_next_ok = cyc + SETTLE + 1;
                end else begin
                    m_e.pos  = 8'(192 + m_bi - 1);
                    m_e.val  = m_buf[m_bi-1];
                    m_e.done = (m_bi == DEPTH);
                    m_next_ok = cyc + 2;
                    if (m_bi == DEPTH) m_active = 0;
                end
                expq.push_back(m_e);
                m_bi++;
            end
            m_wr = i_wr_en && (int'(i_wr_addr) < DEPTH);
            m_pend = m_started ? 1'b0 : (m_pend || i_force);
            if (m_started)
                m_dirty = m_wr;
            else
                m_dirty = m_dirty || m_wr || (!m_was_active && ({i_disp_on, i_bright} != m_last_ctrl));
            if (m_wr) m_buf[i_wr_addr] = i_wr_data;
            m_n++;
        end
    end

    // Monitor: every o_valid must match the oldest predicted byte for exactly this cycle.
    exp_t mon_e;
    always @(negedge CLK) begin
        if (!RST) begin
            while (expq.size() > 0 && expq[0].cyc < cyc) begin
                mon_e = expq.pop_front();
                checks++; errors++;
                $display("FAIL missing_valid cycle=%0d expected pos=%h value=%h at cycle %0d",
                         cyc, mon_e.pos, mon_e.val, mon_e.cyc);
            end
            if (o_valid) begin
                if (expq.size() == 0 || expq[0].cyc != cyc) begin
                    checks++; errors++;
                    $display("FAIL unexpected_valid cycle=%0d got pos=%h value=%h expected no valid",
                             cyc, o_pos, o_value);
                end else begin
                    mon_e = expq.pop_front();
                    chk("pos", o_pos, mon_e.pos);
                    chk("value", o_value, mon_e.val);
                    chk("frame_done", o_frame_done, mon_e.done);
                end
            end else begin
                chk("done_without_valid", o_frame_done, 0);
            end
        end
    end

    // Writer emulation: busy for busy_len cycles starting the cycle after each valid.
    int bcnt = 0;
    bit v_last = 0;
    always @(posedge CLK) begin
        #1;
        if (v_last) bcnt = busy_len;
        i_busy = (bcnt > 0);
        if (bcnt > 0) bcnt--;
        v_last = o_valid;
    end

    task automatic step(input int k);
        repeat (k) @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [7:0] d);
        i_wr_en = 1'b1; i_wr_addr = a; i_wr_data = d;
        step(1);
        i_wr_en = 1'b0;
    endtask

    task automatic pulse_force();
        i_force = 1'b1;
        step(1);
        i_force = 1'b0;
    endtask

    bit found;
    bit drained;

    initial begin
        step(2);
        chk("rst_valid", o_valid, 0);
        chk("rst_busy", o_frame_busy, 0);
        chk("rst_done", o_frame_done, 0);
        chk("rst_tick", o_tick, 0);
        chk("rst_pos", o_pos, 0);
        chk("rst_value", o_value, 0);
        #1 RST = 1'b0;

        // First periodic frame with the reset buffer.
        step(150);
        // Single pixel write then forced refresh.
        wr(2'd2, 8'hA5);
        pulse_force();
        step(45);
        // Slow writer.
        busy_len = 10;
        pulse_force();
        step(110);
        // Force while a frame is in flight, across a tick.
        busy_len = 3;
        pulse_force();
        step(12);
        pulse_force();
        step(200);
        // Brightness change, then let a tick happen.
        i_bright = 3'd5;
        step(120);

        // Abort during the data phase while idx is 2.
        busy_len = 0;
        pulse_force();
        found = 0;
        for (int k = 0; k < 300 && !found; k++) begin
            @(negedge CLK);
            if (o_valid && o_pos == 8'hC1) found = 1;
        end
        chk("reach_idx2", found, 1);
        @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        chk("abort_valid", o_valid, 0);
        chk("abort_busy", o_frame_busy, 0);
        step(2);
        chk("abort_hold_valid", o_valid, 0);
        #1 RST = 1'b0;
        step(160);

        // Randomized traffic.
        for (int k = 0; k < 1500; k++) begin
            i_wr_en = ($urandom_range(0, 7) == 0);
            i_wr_addr = AW'($urandom_range(0, DEPTH - 1));
            i_wr_data = 8'($urandom);
            i_force = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 99) == 0) i_bright = 3'($urandom);
            if ($urandom_range(0, 149) == 0) i_disp_on = ~i_disp_on;
            if ($urandom_range(0, 199) == 0) busy_len = $urandom_range(0, 6);
            step(1);
        end
        i_wr_en = 1'b0;
        i_force = 1'b0;

        drained = 0;
        for (int k = 0; k < 500 && !drained; k++) begin
            step(1);
            if (!m_active && expq.size() == 0) drained = 1;
        end
        chk("drain", drained, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
